// File: rtl/add_arbiter_if.sv
// Request/response bundle between four operand requesters, the shared-adder arbiter and the
// result consumer.
interface add_arbiter_if #(
  parameter int unsigned CNT_W = 8
);
  logic [3:0]       req_valid_in;
  logic [63:0]      req_a_in;
  logic [63:0]      req_b_in;
  logic [3:0]       req_ready_out;
  logic             rsp_valid_out;
  logic             rsp_ready_in;
  logic [1:0]       rsp_id_out;
  logic [15:0]      rsp_sum_out;
  logic             rsp_carry_out;
  logic [CNT_W-1:0] carry_cnt_out;

  modport master (
    output req_valid_in, req_a_in, req_b_in, rsp_ready_in,
    input  req_ready_out, rsp_valid_out, rsp_id_out, rsp_sum_out, rsp_carry_out, carry_cnt_out
  );

  modport slave (
    input  req_valid_in, req_a_in, req_b_in, rsp_ready_in,
    output req_ready_out, rsp_valid_out, rsp_id_out, rsp_sum_out, rsp_carry_out, carry_cnt_out
  );
endinterface

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one 16-bit carry-lookahead adder between four requesters,
// with a registered response port and a saturating carry-event counter.
module add_arbiter #(
  parameter int unsigned CNT_W = 8
) (
  input logic          clk_in,
  input logic          rst_in,
  add_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       rsp_id_q, rsp_id_d;
  logic [15:0]      rsp_sum_q, rsp_sum_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       any_valid, can_accept, grant_fire;
  logic [1:0] grant_idx, arb_idx;
  logic [3:0] grant_oh;
  logic [15:0] op_a, op_b, add_sum;
  logic        add_carry;

  // Scan from lowest priority to highest so the first valid after ptr is left standing.
  always_comb begin
    grant_idx = '0;
    any_valid = 1'b0;
    arb_idx   = '0;
    for (int k = 3; k >= 0; k--) begin
      arb_idx = ptr_q + 2'(k);
      if (bus.req_valid_in[arb_idx]) begin
        grant_idx = arb_idx;
        any_valid = 1'b1;
      end
    end
  end

  assign can_accept = (state_q == StEmpty) || bus.rsp_ready_in;
  assign grant_fire = can_accept && any_valid && !rst_in;
  assign grant_oh   = grant_fire ? (4'b0001 << grant_idx) : 4'b0000;

  assign op_a = bus.req_a_in[16*grant_idx +: 16];
  assign op_b = bus.req_b_in[16*grant_idx +: 16];

  // Two-level carry lookahead: 4-bit groups, group carries resolved in one step, no carry-in.
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;
  always_comb begin
    g = op_a & op_b;
    p = op_a ^ op_b;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = 1'b0;
    gc[1] = gg[0];
    gc[2] = gg[1] | (gp[1] & gg[0]);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k]) |
                 (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    add_sum   = p ^ c;
    add_carry = gc[4];
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StEmpty: if (grant_fire) state_d = StFull;
      StFull:  if (!grant_fire && bus.rsp_ready_in) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
    if (grant_fire) begin
      ptr_d       = grant_idx + 2'd1;
      rsp_id_d    = grant_idx;
      rsp_sum_d   = add_sum;
      rsp_carry_d = add_carry;
      if (add_carry && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StEmpty;
      ptr_q       <= '0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.req_ready_out = grant_oh;
  assign bus.rsp_valid_out = (state_q == StFull);
  assign bus.rsp_id_out    = rsp_id_q;
  assign bus.rsp_sum_out   = rsp_sum_q;
  assign bus.rsp_carry_out = rsp_carry_q;
  assign bus.carry_cnt_out = cnt_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: directed vector table, saturation sequence and random traffic, all
// checked against a transaction-level reference model.
module tb_add_arbiter;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  add_arbiter_if #(.CNT_W(8)) bus ();

  add_arbiter #(.CNT_W(8)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         m_ptr;
  bit         m_valid;
  int         m_id;
  logic [15:0] m_sum;
  bit         m_carry;
  int         m_cnt;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [1:0]  exp_id;
    logic [15:0] exp_sum;
    logic        exp_carry;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic [3:0] v, logic [15:0] a, logic [15:0] b,
                              logic rdy, logic [3:0] er, logic ev, logic [1:0] eid,
                              logic [15:0] es, logic ec, logic [7:0] ecnt);
    vec_t t;
    t.rst = rst; t.valid = v; t.a = a; t.b = b; t.rdy = rdy;
    t.exp_ready = er; t.exp_valid = ev; t.exp_id = eid; t.exp_sum = es;
    t.exp_carry = ec; t.exp_cnt = ecnt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with model updated and compared.
  task automatic step(input logic rst, input logic [3:0] v, input logic [63:0] a,
                      input logic [63:0] b, input logic rdy);
    int          gsel;
    int          idx;
    logic [3:0]  exp_rdy;
    logic [16:0] s17;
    rst_in           = rst;
    bus.req_valid_in = v;
    bus.req_a_in     = a;
    bus.req_b_in     = b;
    bus.rsp_ready_in = rdy;
    #1;
    gsel    = -1;
    exp_rdy = 4'b0000;
    if (!rst && (!m_valid || rdy)) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (gsel < 0 && v[idx]) gsel = idx;
      end
    end
    if (gsel >= 0) exp_rdy[gsel] = 1'b1;
    chk("model_req_ready", 32'(bus.req_ready_out), 32'(exp_rdy));
    @(posedge clk_in);
    if (rst) begin
      m_ptr = 0; m_valid = 0; m_id = 0; m_sum = '0; m_carry = 0; m_cnt = 0;
    end else if (gsel >= 0) begin
      s17     = {1'b0, a[16*gsel +: 16]} + {1'b0, b[16*gsel +: 16]};
      m_valid = 1;
      m_id    = gsel;
      m_sum   = s17[15:0];
      m_carry = s17[16];
      m_ptr   = (gsel + 1) % 4;
      if (m_carry && m_cnt < 255) m_cnt++;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    @(negedge clk_in);
    chk("model_rsp_valid", 32'(bus.rsp_valid_out), 32'(m_valid));
    chk("model_rsp_id",    32'(bus.rsp_id_out),    32'(m_id));
    chk("model_rsp_sum",   32'(bus.rsp_sum_out),   32'(m_sum));
    chk("model_rsp_carry", 32'(bus.rsp_carry_out), 32'(m_carry));
    chk("model_carry_cnt", 32'(bus.carry_cnt_out), 32'(m_cnt));
  endtask

  initial begin
    rst_in           = 1'b1;
    bus.req_valid_in = '0;
    bus.req_a_in     = '0;
    bus.req_b_in     = '0;
    bus.rsp_ready_in = 1'b0;
    m_ptr = 0; m_valid = 0; m_id = 0; m_sum = '0; m_carry = 0; m_cnt = 0;

    // Directed vectors: operands replicated to every lane, expected values hand-derived.
    tbl.push_back(mk(1, 4'b1111, 16'h0000, 16'h0000, 1, 4'b0000, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(1, 4'b1111, 16'h0000, 16'h0000, 1, 4'b0000, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 16'h1234, 16'h4321, 1, 4'b0100, 1, 2, 16'h5555, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 16'hFFFF, 16'h0001, 1, 4'b0001, 1, 0, 16'h0000, 1, 1));
    tbl.push_back(mk(0, 4'b0001, 16'h8000, 16'h8000, 1, 4'b0001, 1, 0, 16'h0000, 1, 2));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 0, 0, 16'h0000, 1, 2));
    tbl.push_back(mk(1, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 0, 0, 16'h0000, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 4'b1111, 16'h0100, 16'h0001, 1, 4'(1 << (i % 4)), 1, 2'(i % 4),
                       16'h0101, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 16'h0100, 16'h0001, 1, 4'b0010, 1, 1, 16'h0101, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 4'b1001, 16'h0300, 16'h0001, 0, 4'b0000, 1, 1, 16'h0101, 0, 0));
    tbl.push_back(mk(0, 4'b1001, 16'h0200, 16'h0001, 1, 4'b1000, 1, 3, 16'h0201, 0, 0));
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(0, 4'b0001, 16'hFFFF, 16'h0001, 1, 4'b0001, 1, 0, 16'h0000, 1, 8'(i)));
    tbl.push_back(mk(1, 4'b1111, 16'h0000, 16'h0000, 0, 4'b0000, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 16'h0001, 16'h0002, 1, 4'b0001, 1, 0, 16'h0003, 0, 0));

    @(negedge clk_in);
    foreach (tbl[i]) begin
      logic [3:0] rdy_seen;
      rst_in           = tbl[i].rst;
      bus.req_valid_in = tbl[i].valid;
      bus.req_a_in     = {4{tbl[i].a}};
      bus.req_b_in     = {4{tbl[i].b}};
      bus.rsp_ready_in = tbl[i].rdy;
      #1;
      rdy_seen = bus.req_ready_out;
      step(tbl[i].rst, tbl[i].valid, {4{tbl[i].a}}, {4{tbl[i].b}}, tbl[i].rdy);
      chk($sformatf("vec%0d_ready", i), 32'(rdy_seen),          32'(tbl[i].exp_ready));
      chk($sformatf("vec%0d_valid", i), 32'(bus.rsp_valid_out), 32'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_id", i),    32'(bus.rsp_id_out),    32'(tbl[i].exp_id));
      chk($sformatf("vec%0d_sum", i),   32'(bus.rsp_sum_out),   32'(tbl[i].exp_sum));
      chk($sformatf("vec%0d_carry", i), 32'(bus.rsp_carry_out), 32'(tbl[i].exp_carry));
      chk($sformatf("vec%0d_cnt", i),   32'(bus.carry_cnt_out), 32'(tbl[i].exp_cnt));
    end

    // Counter saturation: 254 carries, then three more must pin at 255.
    step(1, 4'b0000, '0, '0, 1);
    for (int i = 0; i < 254; i++) step(0, 4'b0001, {4{16'hFFFF}}, {4{16'h0001}}, 1);
    chk("sat_254", 32'(bus.carry_cnt_out), 32'd254);
    for (int i = 0; i < 3; i++) begin
      step(0, 4'b0001, {4{16'h8000}}, {4{16'h8000}}, 1);
      chk($sformatf("sat_255_%0d", i), 32'(bus.carry_cnt_out), 32'd255);
    end

    // Random traffic with occasional resets and backpressure.
    for (int i = 0; i < 500; i++) begin
      logic        r;
      logic [3:0]  v;
      logic [63:0] a, b;
      logic        rdy;
      r   = ($urandom_range(63) == 0);
      v   = 4'($urandom_range(15));
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      rdy = ($urandom_range(3) != 0);
      step(r, v, a, b, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_arbiter.md
# add_arbiter

Round-robin arbiter that shares one 16-bit carry-lookahead adder (BigAdder) between four requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, registers the 16-bit sum, the carry-out and the requester ID, and returns them on a single response port with backpressure. It sits between the scalar issue logic and the shared adder. It also keeps a saturating count of carry-out events for debug.

## Interface
- CNT_W, 8, width of the carry-event counter.
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  synchronous reset, active-high.
- req_valid_in  input  4  bit i: requester i has an operand pair.
- req_a_in  input  64  operand A; requester i on bits [16i+15:16i].
- req_b_in  input  64  operand B; same packing as req_a_in.
- req_ready_out  output  4  bit i: requester i is accepted this cycle (one-hot or zero).
- rsp_valid_out  output  1  response register holds a result.
- rsp_ready_in  input  1  consumer accepts the response this cycle.
- rsp_id_out  output  2  index of the requester that owns the response.
- rsp_sum_out  output  16  (A + B) mod 2^16.
- rsp_carry_out  output  1  bit 16 of the true 17-bit sum A + B.
- carry_cnt_out  output  CNT_W  number of accepted operations with carry = 1; saturates at all-ones.

## Operation
- A transfer on requester i happens when req_valid_in[i] and req_ready_out[i] are both 1.
- A response transfer happens when rsp_valid_out and rsp_ready_in are both 1.
- The output register can accept when `can_accept = !rsp_valid_out || rsp_ready_in`.
- Arbitration is combinational on the current inputs:
  - Priority order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The grant goes to the first valid requester in that order.
  - req_ready_out = one-hot grant when can_accept = 1 and at least one valid is set; otherwise 4'b0000.
  - req_ready_out must not depend on rsp_valid_out in any way other than through can_accept.
- On a grant to requester g:
  - The muxed operands of g drive the single adder instance.
  - The sum and carry are captured into the rsp_* registers.
  - rsp_id_out <= g.
  - rsp_valid_out <= 1.
  - ptr <= (g + 1) mod 4.
- With no grant, ptr holds.
- If a response is drained (rsp_valid_out && rsp_ready_in) and there is no new grant in the same cycle:
  - rsp_valid_out <= 0.
  - rsp_id_out, rsp_sum_out and rsp_carry_out hold their last values.
- Drain and new grant in the same cycle: the new result replaces the old one, rsp_valid_out stays 1, and there is no bubble.
- Arithmetic rules:
  - The 17-bit sum is computed unsigned.
  - rsp_carry_out is the true carry out of bit 15.
  - The adder has no carry-in, so carry-in is 0.
- carry_cnt_out increments by 1 on every accepted request whose carry is 1. Once at 2^CNT_W-1 it holds.
- The state machine is implicit in two registers: EMPTY (rsp_valid_out = 0) and FULL (rsp_valid_out = 1).
  - EMPTY -> FULL on a grant.
  - FULL -> FULL while rsp_ready_in = 0 (all req_ready_out = 0), or on a simultaneous drain and grant.
  - FULL -> EMPTY on a drain with no valid requester.
- Requesters may drop req_valid_in without being granted; the arbiter keeps no memory of past requests.

## Timing
- Reset values, one cycle after rst_in = 1 at an edge:
  - rsp_valid_out = 0, rsp_id_out = 0, rsp_sum_out = 0, rsp_carry_out = 0.
  - carry_cnt_out = 0, ptr = 0.
  - req_ready_out = 4'b0000 while rst_in = 1.
- Reset mid-operation: a pending response is discarded, with no drain required. The counter clears.
- Latency: a request accepted at edge N has its result visible on rsp_* after edge N.
  - This is 1 cycle from req_valid to rsp_valid when the register is empty.
- Throughput: one operation per cycle while rsp_ready_in = 1.
- Under backpressure (rsp_valid_out = 1, rsp_ready_in = 0), rsp_* are stable and no request is accepted.
- Fairness: with all four requesters continuously valid and rsp_ready_in = 1, the grants are 0,1,2,3,0,… Each requester waits at most 3 grants.

## Test plan
- Reset, then one request from requester 2 with A = 0x1234, B = 0x4321 and rsp_ready_in = 1:
  - req_ready_out = 4'b0100 in the same cycle.
  - Next cycle: rsp_valid_out = 1, rsp_id_out = 2, rsp_sum_out = 0x5555, rsp_carry_out = 0.
- Carry and wrap, requester 0 with A = 0xFFFF, B = 0x0001:
  - rsp_sum_out = 0x0000, rsp_carry_out = 1, carry_cnt_out goes 0 -> 1.
  - Repeat with A = 0x8000, B = 0x8000: sum = 0x0000, carry = 1, count = 2.
- All four requesters valid for 8 cycles with rsp_ready_in = 1:
  - rsp_id_out sequence is 0,1,2,3,0,1,2,3 on consecutive cycles, with rsp_valid_out continuously 1.
- Backpressure: fill with requester 1, then hold rsp_ready_in = 0 for 5 cycles while requesters 0 and 3 are valid:
  - req_ready_out = 0 and rsp_* are unchanged for those 5 cycles.
  - When rsp_ready_in = 1 is released, requester 3 is granted first (ptr = 2, so the order is 2,3,0,1).
- Assert rst_in for one cycle while rsp_valid_out = 1 and carry_cnt_out = 5:
  - Next cycle all outputs are 0 and the next grant starts from requester 0.
- Force the counter to 254, then send three carry-producing requests:
  - carry_cnt_out goes 255, 255, 255.
